data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and access sequencer that shares the single-port `data_memory` between two requesters: the controller's load/store path (port 0) and a secondary master such as a loader or debug port (port 1). It registers the selected request onto the memory strobes, returns read data with a valid pulse, and supports short locked bursts with a bounded length. It sits between the requesters and `data_memory`, and owns the `addr`, `write_data`, `mem_read` and `mem_write` inputs of the memory exclusively.

## Interface
- `ADDR_W`, 8, address width.
- `DATA_W`, 8, data width.
- `MAX_BURST`, 4, maximum consecutive locked grants to one owner (legal range 1..15).

- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `req0`, `req1`  input  1  access request; held until the matching `gnt` is seen.
- `we0`, `we1`  input  1  1 = write, 0 = read; stable while `req` is high.
- `lock0`, `lock1`  input  1  asks to keep ownership for the next access.
- `addr0`, `addr1`  input  ADDR_W  access address.
- `wdata0`, `wdata1`  input  DATA_W  write data.
- `gnt0`, `gnt1`  output  1  one-cycle pulse: the request has been accepted and driven to memory.
- `rdata0`, `rdata1`  output  DATA_W  captured read data; holds until the next read for that port.
- `rvalid0`, `rvalid1`  output  1  one-cycle pulse: `rdata` is updated (reads only).
- `mem_addr`  output  ADDR_W  to `data_memory.addr`.
- `mem_wdata`  output  DATA_W  to `data_memory.write_data`.
- `mem_read`, `mem_write`  output  1  memory strobes; at most one is high.
- `mem_rdata`  input  DATA_W  from `data_memory.read_data`.

## Operation
- **FSM has two states: IDLE and ACCESS.**
- **IDLE:**
  - With no `req` high, the FSM stays in IDLE and all strobes are 0.
  - Otherwise the arbiter picks a winner, registers its `addr`/`wdata` onto `mem_addr`/`mem_wdata`, and registers `mem_write = we` and `mem_read = !we`.
  - It pulses the winner's `gnt` and moves to ACCESS.
- **ACCESS:**
  - All `req` inputs are ignored.
  - On the next edge, if the access was a read, `mem_rdata` is captured into the owner's `rdata` and its `rvalid` pulses.
  - Strobes clear and the FSM returns to IDLE unconditionally.
- **Winner selection:**
  - **Locked owner:** if a locked owner exists and its `req` is high, it wins regardless of priority.
  - **Otherwise:** the priority rule under Configuration decides.
  - **Sole requester:** a single requesting port always wins.
- **Lock rules:**
  - A grant to port i with `lock_i` = 1 makes i the locked owner and increments `burst_cnt`.
  - A grant with `lock_i` = 0 clears ownership and `burst_cnt`.
  - When `burst_cnt` reaches `MAX_BURST`, ownership is cleared and `burst_cnt` is set to 0 at that grant, even if lock is held.
  - The non-owner then has priority for the next arbitration only if it is requesting.
  - If the locked owner drops `req` while in IDLE, ownership clears and normal arbitration applies in the same cycle.
- **Priority pointer:** `last` records the most recently granted port. It updates only on a grant.
- **Reset values:**
  - FSM in IDLE; `last` = 1, so port 0 has first priority.
  - No owner; `burst_cnt` = 0.
  - All `gnt`, `rvalid`, `mem_read` and `mem_write` = 0.
  - `mem_addr`, `mem_wdata`, `rdata0` and `rdata1` = 0.
- **Reset mid-access:** if `reset` is low at the ACCESS edge, the FSM returns to IDLE, no `rvalid` is issued, strobes clear, and the pending read is dropped. A write whose strobe was already high for that cycle has reached memory.

## Timing
- **Request to grant:** a request sampled high at IDLE edge k gives `gnt` and the memory strobes high for the cycle after edge k.
- **Read data:** `rvalid` is high for the cycle after edge k+1, and `rdata` is valid from then on.
- **Requester obligations:**
  - Keep `req`/`we`/`addr`/`wdata` stable until the edge where `gnt` is high.
  - It may change them or issue a new request for the edge after that (k+2), which is the next IDLE sample.
- **Throughput:** at most one access every 2 cycles. Back-to-back requests from one port complete at edges k, k+2, k+4, ...
- **Same-cycle events:** `gnt` for a new access and `rvalid` for a previous access never occur in the same cycle.
- **Strobe timing:** `mem_read`/`mem_write` are high for exactly one cycle per access. `data_memory` is treated as a combinational read within that cycle.

## Configuration
- **Macro `DM_ARB_RR_EN`.**
- **Defined (round-robin):** on contention with no locked owner, the port ≠ `last` wins, so alternating requesters get alternating grants.
- **Undefined (fixed priority):**
  - Port 0 always wins contention with no locked owner; `last` is not used for priority.
  - Lock and `MAX_BURST` behave identically to the round-robin build.
  - When `MAX_BURST` is reached for port 0, port 1 still gets the next slot if requesting.

## Test plan
- **Single read:** after reset release, `req0`=1, `we0`=0, `addr0`=0x10, with memory[0x10]=0xA5 → `gnt0` pulses one cycle later, `mem_read`=1 with `mem_addr`=0x10 in that cycle, `rvalid0` pulses the next cycle, `rdata0`=0xA5, `gnt1`/`rvalid1` stay 0.
- **Contention, round-robin:** with `DM_ARB_RR_EN`, `req0` and `req1` held high continuously, both writes (wdata 0x11/0x22) → grants go 0,1,0,1 on alternate-cycle slots. Undefined build → grants go 0,0,0,0 until `req0` drops.
- **Burst limit:** `lock1`=1, `req1` held, `req0` held, `MAX_BURST`=4 → four consecutive `gnt1`, then `gnt0`, then port 1 is eligible again; `burst_cnt` returns to 0 after the fourth grant.
- **Lock release:** `lock0`=1 for 2 grants, then `lock0`=0 on the third with `req1` high → the third grant goes to port 0, the next goes to port 1 in both builds.
- **Reset mid-read:** `reset` driven low in the ACCESS cycle of a port-1 read → no `rvalid1`, `rdata1`=0, strobes 0 on the next cycle, FSM in IDLE, first post-reset contention goes to port 0.
- **Write then read:** port 0 writes 0x3C to 0x20, then reads 0x20 → `mem_write` high for one cycle with correct address/data, `rvalid0` absent for the write, `rdata0`=0x3C after the read.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port data_memory.
// Macro DM_ARB_RR_EN selects round-robin contention; when undefined, port 0 has fixed priority.
module data_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_state,
    output logic [3:0]        dbg_burst_cnt
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state;
    logic        last;
    logic        owner_vld;
    logic        owner;
    logic        yield_vld;
    logic        yield_to;
    logic        cur;
    logic        cur_rd;
    logic [3:0]  burst_cnt;

    logic              any_req;
    logic              lock_hit;
    logic              win;
    logic              win_we;
    logic              win_lock;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [3:0]        next_cnt;

    // A locked owner that dropped its request no longer counts; arbitration falls through.
    always_comb begin
        any_req  = req0 | req1;
        lock_hit = owner_vld && (owner ? req1 : req0);
        if (lock_hit)
            win = owner;
        else if (req0 && !req1)
            win = 1'b0;
        else if (req1 && !req0)
            win = 1'b1;
        else if (yield_vld)
            win = yield_to;
        else
`ifdef DM_ARB_RR_EN
            win = ~last;
`else
            win = 1'b0;
`endif
        win_we    = win ? we1 : we0;
        win_lock  = win ? lock1 : lock0;
        win_addr  = win ? addr1 : addr0;
        win_wdata = win ? wdata1 : wdata0;
        next_cnt  = (lock_hit ? burst_cnt : 4'd0) + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner_vld <= 1'b0;
            owner     <= 1'b0;
            yield_vld <= 1'b0;
            yield_to  <= 1'b0;
            cur       <= 1'b0;
            cur_rd    <= 1'b0;
            burst_cnt <= 4'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (any_req) begin
                        state     <= ACCESS;
                        cur       <= win;
                        cur_rd    <= !win_we;
                        last      <= win;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        mem_write <= win_we;
                        mem_read  <= !win_we;
                        gnt0      <= !win;
                        gnt1      <= win;
                        yield_vld <= 1'b0;
                        if (win_lock && (next_cnt < 4'(MAX_BURST))) begin
                            owner_vld <= 1'b1;
                            owner     <= win;
                            burst_cnt <= next_cnt;
                        end else begin
                            owner_vld <= 1'b0;
                            burst_cnt <= 4'd0;
                            // Burst exhausted: the other port gets the next contended slot.
                            if (win_lock) begin
                                yield_vld <= 1'b1;
                                yield_to  <= ~win;
                            end
                        end
                    end else if (owner_vld) begin
                        owner_vld <= 1'b0;
                        burst_cnt <= 4'd0;
                    end
                end
                ACCESS: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (cur_rd) begin
                        if (cur) begin
                            rdata1  <= mem_rdata;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= mem_rdata;
                            rvalid0 <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state     = (state == ACCESS);
    assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: grant/read scoreboard queues checked by a negedge monitor.
module tb_data_mem_arbiter;

    localparam int GW = 18;
    localparam int RW = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic       lock0 = 1'b0, lock1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, dbg_state;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [3:0] dbg_burst_cnt;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [GW-1:0] exp_q[$];
    logic [RW-1:0] rd_q[$];

    logic [7:0]   mem [0:255];
    logic [255:0] mem_wr = '0;
    logic [7:0]   ref_mem [0:255];
    logic [255:0] ref_wr = '0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_burst_cnt(dbg_burst_cnt)
    );

    // Memory model: unwritten locations read back as addr ^ 0xB5 (so 0x10 holds 0xA5).
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr]    <= mem_wdata;
            mem_wr[mem_addr] <= 1'b1;
        end
    end
    assign mem_rdata = mem_wr[mem_addr] ? mem[mem_addr] : (mem_addr ^ 8'hB5);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ref_val(input logic [7:0] a);
        return ref_wr[a] ? ref_mem[a] : (a ^ 8'hB5);
    endfunction

    task automatic push_acc(input logic port, input logic we, input logic [7:0] a,
                            input logic [7:0] d, input logic expect_rd);
        exp_q.push_back({port, we, a, we ? d : 8'h00});
        if (we) begin
            ref_mem[a] = d;
            ref_wr[a]  = 1'b1;
        end else if (expect_rd) begin
            rd_q.push_back({port, ref_val(a)});
        end
    endtask

    task automatic wait_gnt(input logic port, input int exp_lat, input string tag);
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = port ? gnt1 : gnt0;
        end
        check({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: every grant and every read return must match the head of its queue.
    always @(negedge clk) begin
        logic [GW-1:0] eg;
        logic [RW-1:0] er;
        if (mon_en) begin
            check("gnt_onehot", gnt0 & gnt1, 0);
            if (gnt0 | gnt1) begin
                check("gnt_rvalid_overlap", rvalid0 | rvalid1, 0);
                check("strobe_onehot", mem_read ^ mem_write, 1);
                check("gnt_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    eg = exp_q.pop_front();
                    check("grant", {gnt1, mem_write, mem_addr, mem_write ? mem_wdata : 8'h00}, eg);
                end
            end else begin
                check("idle_strobes", {mem_read, mem_write}, 0);
            end
            if (rvalid0 | rvalid1) begin
                check("rvalid_onehot", rvalid0 & rvalid1, 0);
                check("rvalid_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    er = rd_q.pop_front();
                    check("read_data", {rvalid1, rvalid1 ? rdata1 : rdata0}, er);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", {rdata0, rdata1}, 0);
        check("rst_state", dbg_state, 0);
        check("rst_burst", dbg_burst_cnt, 0);
        mon_en = 1'b1;
        reset  = 1'b1;

        // Single read of 0x10
        push_acc(0, 0, 8'h10, 8'h00, 1);
        req0 = 1; we0 = 0; addr0 = 8'h10;
        wait_gnt(0, 1, "rd_gnt");
        check("rd_strobe", {mem_read, mem_addr}, {1'b1, 8'h10});
        check("rd_gnt1", gnt1, 0);
        req0 = 0;
        @(negedge clk);
        check("rd_rvalid", {rvalid0, rvalid1}, 2'b10);
        check("rd_rdata", rdata0, 8'hA5);

        // Write 0x3C to 0x20, then read it back
        push_acc(0, 1, 8'h20, 8'h3C, 0);
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h3C;
        wait_gnt(0, 1, "wr_gnt");
        check("wr_strobe", {mem_write, mem_read, mem_addr, mem_wdata}, {2'b10, 8'h20, 8'h3C});
        push_acc(0, 0, 8'h20, 8'h00, 1);
        we0 = 0;
        @(negedge clk);
        check("wr_no_rvalid", rvalid0, 0);
        check("wr_strobe_once", mem_write, 0);
        wait_gnt(0, 1, "wr_rd_gnt");
        req0 = 0;
        @(negedge clk);
        check("wr_rd_rdata", rdata0, 8'h3C);

        // Contention, both ports writing continuously
        do_reset();
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 8'h31; wdata1 = 8'h22;
`ifdef DM_ARB_RR_EN
        push_acc(0, 1, 8'h30, 8'h11, 0);
        push_acc(1, 1, 8'h31, 8'h22, 0);
        push_acc(0, 1, 8'h30, 8'h11, 0);
        push_acc(1, 1, 8'h31, 8'h22, 0);
        wait_gnt(0, 1, "rr_g0");
        wait_gnt(1, 2, "rr_g1");
        wait_gnt(0, 2, "rr_g2");
        req0 = 0;
        wait_gnt(1, 2, "rr_g3");
        req1 = 0;
`else
        for (int i = 0; i < 4; i++) push_acc(0, 1, 8'h30, 8'h11, 0);
        push_acc(1, 1, 8'h31, 8'h22, 0);
        wait_gnt(0, 1, "fp_g0");
        wait_gnt(0, 2, "fp_g1");
        wait_gnt(0, 2, "fp_g2");
        wait_gnt(0, 2, "fp_g3");
        req0 = 0;
        wait_gnt(1, 2, "fp_g4");
        req1 = 0;
`endif

        // Port 1 locked burst against a waiting port 0
        do_reset();
        push_acc(1, 1, 8'h40, 8'h55, 0);
        lock1 = 1; req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 8'h55;
        wait_gnt(1, 1, "b1_g1");
        check("b1_cnt1", dbg_burst_cnt, 1);
        req0 = 1; we0 = 1; addr0 = 8'h41; wdata0 = 8'h66;
        for (int i = 0; i < 3; i++) push_acc(1, 1, 8'h40, 8'h55, 0);
        push_acc(0, 1, 8'h41, 8'h66, 0);
        wait_gnt(1, 2, "b1_g2");
        check("b1_cnt2", dbg_burst_cnt, 2);
        wait_gnt(1, 2, "b1_g3");
        check("b1_cnt3", dbg_burst_cnt, 3);
        wait_gnt(1, 2, "b1_g4");
        check("b1_cnt_wrap", dbg_burst_cnt, 0);
        wait_gnt(0, 2, "b1_g5");
        req0 = 0;
        push_acc(1, 1, 8'h40, 8'h55, 0);
        wait_gnt(1, 2, "b1_g6");
        check("b1_cnt_new", dbg_burst_cnt, 1);
        req1 = 0; lock1 = 0;
        repeat (2) @(negedge clk);
        check("b1_owner_drop", dbg_burst_cnt, 0);

        // Port 0 locked burst: port 1 must get the slot after the limit
        do_reset();
        lock0 = 1; req0 = 1; we0 = 1; addr0 = 8'h42; wdata0 = 8'h12;
        req1 = 1; we1 = 1; addr1 = 8'h43; wdata1 = 8'h34;
        for (int i = 0; i < 4; i++) push_acc(0, 1, 8'h42, 8'h12, 0);
        push_acc(1, 1, 8'h43, 8'h34, 0);
        wait_gnt(0, 1, "b0_g1");
        wait_gnt(0, 2, "b0_g2");
        wait_gnt(0, 2, "b0_g3");
        wait_gnt(0, 2, "b0_g4");
        check("b0_cnt_wrap", dbg_burst_cnt, 0);
        wait_gnt(1, 2, "b0_yield");
        clear_inputs();

        // Lock held for two grants, released on the third
        do_reset();
        lock0 = 1; req0 = 1; we0 = 1; addr0 = 8'h44; wdata0 = 8'h21;
        req1 = 1; we1 = 1; addr1 = 8'h45; wdata1 = 8'h43;
        for (int i = 0; i < 3; i++) push_acc(0, 1, 8'h44, 8'h21, 0);
        push_acc(1, 1, 8'h45, 8'h43, 0);
        wait_gnt(0, 1, "lr_g1");
        check("lr_cnt1", dbg_burst_cnt, 1);
        wait_gnt(0, 2, "lr_g2");
        check("lr_cnt2", dbg_burst_cnt, 2);
        lock0 = 0;
        wait_gnt(0, 2, "lr_g3");
        check("lr_cnt_rel", dbg_burst_cnt, 0);
        req0 = 0;
        wait_gnt(1, 2, "lr_g4");
        clear_inputs();
        repeat (2) @(negedge clk);

        // Port 1 read, then a port 1 read killed by reset in its ACCESS cycle
        push_acc(1, 0, 8'h52, 8'h00, 1);
        req1 = 1; we1 = 0; addr1 = 8'h52;
        wait_gnt(1, 1, "mr_pre_gnt");
        req1 = 0;
        @(negedge clk);
        check("mr_pre_rdata", rdata1, 8'hE7);
        push_acc(1, 0, 8'h50, 8'h00, 0);
        req1 = 1; addr1 = 8'h50;
        wait_gnt(1, 1, "mr_gnt");
        req1 = 0;
        reset = 1'b0;
        @(negedge clk);
        check("mr_rvalid", rvalid1, 0);
        check("mr_rdata", rdata1, 0);
        check("mr_strobes", {mem_read, mem_write}, 0);
        check("mr_state", dbg_state, 0);
        reset = 1'b1;
        push_acc(0, 1, 8'h60, 8'h5A, 0);
        push_acc(1, 1, 8'h61, 8'hA5, 0);
        req0 = 1; we0 = 1; addr0 = 8'h60; wdata0 = 8'h5A;
        req1 = 1; we1 = 1; addr1 = 8'h61; wdata1 = 8'hA5;
        wait_gnt(0, 1, "mr_post_g0");
        req0 = 0;
        wait_gnt(1, 2, "mr_post_g1");
        req1 = 0;

        repeat (4) @(negedge clk);
        check("grant_queue_drained", exp_q.size(), 0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
